// File: rtl/register_tree_pq.sv
// Register-tree priority queue: every node holds {valid, key, tag}, and a two-pass
// compare-swap sweep re-settles the heap after each accepted enqueue/dequeue/replace.
module register_tree_pq #(
    parameter int QUEUE_SIZE = 15,
    parameter int KEY_WIDTH  = 16,
    parameter int TAG_WIDTH  = 8,
    parameter int MIN_HEAP   = 0,
    parameter int ENQ_ENA    = 1
) (
    input  logic                             i_CLK,
    input  logic                             i_RST,
    input  logic                             i_wrt,
    input  logic                             i_read,
    input  logic [KEY_WIDTH-1:0]             i_key,
    input  logic [TAG_WIDTH-1:0]             i_tag,
    output logic                             o_ready,
    output logic                             o_valid,
    output logic [KEY_WIDTH-1:0]             o_key,
    output logic [TAG_WIDTH-1:0]             o_tag,
    output logic [$clog2(QUEUE_SIZE+1)-1:0]  o_count,
    output logic                             o_full,
    output logic                             o_empty,
    output logic                             o_err
);
    localparam int TREE_DEPTH = $clog2(QUEUE_SIZE + 1);
    localparam int NODES      = (1 << TREE_DEPTH) - 1;
    localparam int IW         = (NODES > 1) ? $clog2(NODES) : 1;
    localparam int CW         = TREE_DEPTH;
    localparam logic [CW-1:0] FULL_CNT = CW'(QUEUE_SIZE);

    logic [KEY_WIDTH-1:0] key_q [NODES];
    logic [TAG_WIDTH-1:0] tag_q [NODES];
    logic [NODES-1:0]     vld_q;
    logic [CW-1:0]        cnt_q;
    logic                 dirty_q;
    logic                 err_q;

    logic [KEY_WIDTH-1:0] key_s [NODES];
    logic [TAG_WIDTH-1:0] tag_s [NODES];
    logic [NODES-1:0]     vld_s;
    logic                 swapped;
    logic [IW-1:0]        p_i, l_i, r_i, c_i;
    logic [KEY_WIDTH-1:0] t_key;
    logic [TAG_WIDTH-1:0] t_tag;
    logic                 t_vld;
    logic [IW-1:0]        free_idx;

    logic accept, do_rep, do_deq, do_enq;

    // A valid node outranks an invalid one; equal keys never outrank each other.
    function automatic logic outranks(input logic va, input logic [KEY_WIDTH-1:0] ka,
                                      input logic vb, input logic [KEY_WIDTH-1:0] kb);
        if (!va) return 1'b0;
        if (!vb) return 1'b1;
        return (MIN_HEAP != 0) ? (ka < kb) : (ka > kb);
    endfunction

    // Pass 0 handles parents on even levels, pass 1 odd levels, chained combinationally.
    always_comb begin
        key_s   = key_q;
        tag_s   = tag_q;
        vld_s   = vld_q;
        swapped = 1'b0;
        p_i     = '0;
        l_i     = '0;
        r_i     = '0;
        c_i     = '0;
        t_key   = '0;
        t_tag   = '0;
        t_vld   = 1'b0;
        for (int unsigned pass = 0; pass < 2; pass++) begin
            for (int unsigned lvl = pass; lvl + 1 < TREE_DEPTH; lvl += 2) begin
                for (int unsigned p = (1 << lvl) - 1; p < (1 << (lvl + 1)) - 1; p++) begin
                    p_i = IW'(p);
                    l_i = IW'(2 * p + 1);
                    r_i = IW'(2 * p + 2);
                    c_i = outranks(vld_s[r_i], key_s[r_i], vld_s[l_i], key_s[l_i]) ? r_i : l_i;
                    if (outranks(vld_s[c_i], key_s[c_i], vld_s[p_i], key_s[p_i])) begin
                        t_key        = key_s[p_i];
                        t_tag        = tag_s[p_i];
                        t_vld        = vld_s[p_i];
                        key_s[p_i]   = key_s[c_i];
                        tag_s[p_i]   = tag_s[c_i];
                        vld_s[p_i]   = vld_s[c_i];
                        key_s[c_i]   = t_key;
                        tag_s[c_i]   = t_tag;
                        vld_s[c_i]   = t_vld;
                        swapped      = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        free_idx = '0;
        for (int unsigned j = NODES; j > 0; j--) begin
            if (!vld_q[IW'(j - 1)]) free_idx = IW'(j - 1);
        end
    end

    assign accept = !dirty_q && (i_wrt || i_read);
    assign do_rep = i_wrt && i_read;
    assign do_deq = i_read && !i_wrt;
    assign do_enq = i_wrt && !i_read && (ENQ_ENA != 0);

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            key_q   <= '{default: '0};
            tag_q   <= '{default: '0};
            vld_q   <= '0;
            cnt_q   <= '0;
            dirty_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (accept) begin
                if (do_rep) begin
                    key_q[0] <= i_key;
                    tag_q[0] <= i_tag;
                    vld_q[0] <= 1'b1;
                    if (cnt_q == '0) cnt_q <= CW'(1);
                    dirty_q  <= 1'b1;
                end else if (do_deq) begin
                    if (cnt_q == '0) begin
                        err_q <= 1'b1;
                    end else begin
                        key_q[0] <= '0;
                        tag_q[0] <= '0;
                        vld_q[0] <= 1'b0;
                        cnt_q    <= cnt_q - 1'b1;
                        dirty_q  <= 1'b1;
                    end
                end else if (do_enq) begin
                    if (cnt_q == FULL_CNT) begin
                        err_q <= 1'b1;
                    end else begin
                        key_q[free_idx] <= i_key;
                        tag_q[free_idx] <= i_tag;
                        vld_q[free_idx] <= 1'b1;
                        cnt_q           <= cnt_q + 1'b1;
                        dirty_q         <= 1'b1;
                    end
                end
            end else if (dirty_q) begin
                key_q <= key_s;
                tag_q <= tag_s;
                vld_q <= vld_s;
                if (!swapped) dirty_q <= 1'b0;
            end
        end
    end

    assign o_ready = !dirty_q;
    assign o_valid = vld_q[0];
    assign o_key   = vld_q[0] ? key_q[0] : '0;
    assign o_tag   = vld_q[0] ? tag_q[0] : '0;
    assign o_count = cnt_q;
    assign o_full  = (cnt_q == FULL_CNT);
    assign o_empty = (cnt_q == '0);
    assign o_err   = err_q;

endmodule
